// File: rtl/crack_dispatch.sv
// crack_dispatch: dispatch controller above two key-search cores.
// Core 0 walks even keys and core 1 walks odd keys.  One accepted request
// starts both cores together, the first valid key wins, the losing core is
// stopped by holding both cores in reset for ABORT_CYCLES, and the result is
// reported upward.
// Optional build macro: CRACK_CYCLE_COUNT_EN adds the search_cycles output,
// a saturating count of cycles spent in RUN.
module crack_dispatch #(
    parameter int KEY_W        = 24,
    parameter int ABORT_CYCLES = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             en,
    output logic             rdy,
    output logic [KEY_W-1:0] key,
    output logic             key_valid,
    output logic             winner,
    output logic [1:0]       core_rst_n,
    output logic [1:0]       core_en,
    input  logic [1:0]       core_rdy,
    input  logic [KEY_W-1:0] core_key0,
    input  logic [KEY_W-1:0] core_key1,
    input  logic [1:0]       core_key_valid
`ifdef CRACK_CYCLE_COUNT_EN
    ,
    output logic [31:0]      search_cycles
`endif
);

    localparam int CNT_W = $clog2(ABORT_CYCLES + 1);
    localparam logic [CNT_W-1:0] CNT_LOAD = CNT_W'(ABORT_CYCLES - 1);

    localparam logic [2:0] IDLE       = 3'd0;
    localparam logic [2:0] WAIT_CORES = 3'd1;
    localparam logic [2:0] RUN        = 3'd2;
    localparam logic [2:0] ABORT      = 3'd3;
    localparam logic [2:0] DONE       = 3'd4;

    logic [2:0]       state;
    logic [1:0]       busy_seen;
    logic [CNT_W-1:0] abort_cnt;
    logic [1:0]       done;
    logic             hit0;
    logic             hit1;

    // A core is finished only once it has been seen busy after the start
    // pulse and then returns to ready; a core still ready right after the
    // pulse has simply not started yet.
    always_comb begin
        done = busy_seen & core_rdy;
        hit0 = done[0] & core_key_valid[0];
        hit1 = done[1] & core_key_valid[1];
    end

    // Dispatch FSM: request handshake, core start, winner latch, abort hold.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            rdy        <= 1'b0;
            key        <= '0;
            key_valid  <= 1'b0;
            winner     <= 1'b0;
            core_en    <= 2'b00;
            core_rst_n <= 2'b00;
            busy_seen  <= 2'b00;
            abort_cnt  <= '0;
        end else begin
            core_en <= 2'b00;
            case (state)
                IDLE: begin
                    core_rst_n <= 2'b11;
                    rdy        <= 1'b1;
                    if (en && rdy) begin
                        key       <= '0;
                        key_valid <= 1'b0;
                        winner    <= 1'b0;
                        rdy       <= 1'b0;
                        state     <= WAIT_CORES;
                    end
                end
                WAIT_CORES: begin
                    if (core_rdy == 2'b11) begin
                        core_en   <= 2'b11;
                        busy_seen <= 2'b00;
                        state     <= RUN;
                    end
                end
                RUN: begin
                    busy_seen <= busy_seen | ~core_rdy;
                    if (hit0) begin
                        key        <= core_key0;
                        key_valid  <= 1'b1;
                        winner     <= 1'b0;
                        core_rst_n <= 2'b00;
                        abort_cnt  <= CNT_LOAD;
                        state      <= ABORT;
                    end else if (hit1) begin
                        key        <= core_key1;
                        key_valid  <= 1'b1;
                        winner     <= 1'b1;
                        core_rst_n <= 2'b00;
                        abort_cnt  <= CNT_LOAD;
                        state      <= ABORT;
                    end else if (done == 2'b11) begin
                        key       <= '0;
                        key_valid <= 1'b0;
                        state     <= DONE;
                    end
                end
                ABORT: begin
                    if (abort_cnt == '0) begin
                        core_rst_n <= 2'b11;
                        state      <= DONE;
                    end else begin
                        abort_cnt <= abort_cnt - 1'b1;
                    end
                end
                DONE: begin
                    rdy   <= 1'b1;
                    state <= IDLE;
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

`ifdef CRACK_CYCLE_COUNT_EN
    function automatic logic [31:0] sat_inc(input logic [31:0] v);
        return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
    endfunction

    // Search duration: cleared on an accepted request, counts RUN cycles.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            search_cycles <= 32'd0;
        end else if (state == IDLE && en && rdy) begin
            search_cycles <= 32'd0;
        end else if (state == RUN) begin
            search_cycles <= sat_inc(search_cycles);
        end
    end
`endif

endmodule

// File: tb/tb_crack_dispatch.sv
// Bench for crack_dispatch: behavioural key-search cores, expected search
// outcomes queued when a search is launched and compared on completion.
module tb_crack_dispatch;

    localparam int KEY_W = 24;
    localparam int AC    = 4;
    localparam int NEVER = 1_000_000;

    logic             clk = 1'b0;
    logic             rst_n;
    logic             en;
    logic             rdy;
    logic [KEY_W-1:0] key;
    logic             key_valid;
    logic             winner;
    logic [1:0]       core_rst_n;
    logic [1:0]       core_en;
    logic [1:0]       m_rdy;
    logic [1:0]       m_kvld;
    logic [KEY_W-1:0] m_key [2];
`ifdef CRACK_CYCLE_COUNT_EN
    logic [31:0]      search_cycles;
`endif

    always #5 clk = ~clk;

    crack_dispatch #(.KEY_W(KEY_W), .ABORT_CYCLES(AC)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .en             (en),
        .rdy            (rdy),
        .key            (key),
        .key_valid      (key_valid),
        .winner         (winner),
        .core_rst_n     (core_rst_n),
        .core_en        (core_en),
        .core_rdy       (m_rdy),
        .core_key0      (m_key[0]),
        .core_key1      (m_key[1]),
        .core_key_valid (m_kvld)
`ifdef CRACK_CYCLE_COUNT_EN
        ,
        .search_cycles  (search_cycles)
`endif
    );

    // Behavioural core: after a start pulse it is busy for c_dur cycles,
    // then shows ready with the programmed verdict and key.
    int               c_dur [2];
    logic             c_val [2];
    logic [KEY_W-1:0] c_kv  [2];
    logic             m_busy [2];
    int               m_cnt  [2];

    always @(posedge clk) begin
        for (int i = 0; i < 2; i++) begin
            if (!core_rst_n[i]) begin
                m_busy[i] <= 1'b0;
                m_rdy[i]  <= 1'b0;
                m_kvld[i] <= 1'b0;
                m_cnt[i]  <= 0;
                m_key[i]  <= '0;
            end else if (m_busy[i]) begin
                if (m_cnt[i] <= 1) begin
                    m_busy[i] <= 1'b0;
                    m_rdy[i]  <= 1'b1;
                    m_kvld[i] <= c_val[i];
                    m_key[i]  <= c_kv[i];
                end else begin
                    m_cnt[i] <= m_cnt[i] - 1;
                    m_key[i] <= m_key[i] + KEY_W'(2);
                end
            end else if (core_en[i]) begin
                m_busy[i] <= 1'b1;
                m_rdy[i]  <= 1'b0;
                m_kvld[i] <= 1'b0;
                m_cnt[i]  <= c_dur[i];
                m_key[i]  <= KEY_W'(i);
            end else begin
                m_rdy[i] <= 1'b1;
            end
        end
    end

    typedef struct packed {
        logic             kv;
        logic [KEY_W-1:0] key;
        logic             win;
        logic [31:0]      n;
        logic [31:0]      ab;
        logic [31:0]      cyc;
    } exp_t;

    exp_t sb[$];
    int   n_tests = 0;
    int   n_fail  = 0;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic wait_rdy();
        int k = 0;
        while (rdy !== 1'b1 && k < 200) begin
            @(negedge clk);
            k++;
        end
        chk("idle_rdy", {31'd0, rdy}, 32'd1);
        repeat (3) @(negedge clk);
    endtask

    // Launch one search and predict its outcome from the core programming.
    task automatic run_search(input int d0, input logic v0, input logic [KEY_W-1:0] k0,
                              input int d1, input logic v1, input logic [KEY_W-1:0] k1);
        exp_t e;
        exp_t g;
        int   t0;
        int   t1;
        int   n;
        int   ab;
        t0 = v0 ? d0 : NEVER;
        t1 = v1 ? d1 : NEVER;
        if (t0 == NEVER && t1 == NEVER) begin
            e.kv  = 1'b0;
            e.key = '0;
            e.win = 1'b0;
            e.n   = 32'((d0 > d1 ? d0 : d1) + 2);
            e.ab  = 32'd0;
            e.cyc = 32'((d0 > d1 ? d0 : d1) + 2);
        end else if (t0 <= t1) begin
            e.kv  = 1'b1;
            e.key = k0;
            e.win = 1'b0;
            e.n   = 32'(d0 + AC + 2);
            e.ab  = 32'(AC);
            e.cyc = 32'(d0 + 2);
        end else begin
            e.kv  = 1'b1;
            e.key = k1;
            e.win = 1'b1;
            e.n   = 32'(d1 + AC + 2);
            e.ab  = 32'(AC);
            e.cyc = 32'(d1 + 2);
        end
        sb.push_back(e);
        c_dur[0] = d0; c_val[0] = v0; c_kv[0] = k0;
        c_dur[1] = d1; c_val[1] = v1; c_kv[1] = k1;

        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        chk("accept_rdy", {31'd0, rdy}, 32'd0);
        chk("accept_kv_clr", {31'd0, key_valid}, 32'd0);
        chk("accept_key_clr", 32'(key), 32'd0);
        chk("accept_coreen", {30'd0, core_en}, 32'd0);
`ifdef CRACK_CYCLE_COUNT_EN
        chk("cyc_clr", search_cycles, 32'd0);
`endif
        @(negedge clk);
        chk("coreen_pulse", {30'd0, core_en}, 32'd3);
        @(negedge clk);
        chk("coreen_one", {30'd0, core_en}, 32'd0);
        n  = 0;
        ab = 0;
        while (rdy !== 1'b1 && n < 2000) begin
            @(negedge clk);
            n++;
            if (core_rst_n == 2'b00) ab++;
        end
        if (n >= 2000) chk("timeout", 32'd1, 32'd0);
        g = sb.pop_front();
        chk("res_kv", {31'd0, key_valid}, {31'd0, g.kv});
        chk("res_key", 32'(key), 32'(g.key));
        chk("res_win", {31'd0, winner}, {31'd0, g.win});
        chk("res_lat", 32'(n), g.n);
        chk("res_abort", 32'(ab), g.ab);
        chk("res_crst", {30'd0, core_rst_n}, 32'd3);
`ifdef CRACK_CYCLE_COUNT_EN
        chk("res_cyc", search_cycles, g.cyc);
`endif
        repeat (3) @(negedge clk);
        chk("hold_kv", {31'd0, key_valid}, {31'd0, g.kv});
        chk("hold_key", 32'(key), 32'(g.key));
`ifdef CRACK_CYCLE_COUNT_EN
        chk("hold_cyc", search_cycles, g.cyc);
`endif
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0;
        en    = 1'b0;
        for (int i = 0; i < 2; i++) begin
            c_dur[i] = 10;
            c_val[i] = 1'b0;
            c_kv[i]  = '0;
        end
        repeat (3) @(negedge clk);
        chk("rst_rdy", {31'd0, rdy}, 32'd0);
        chk("rst_crst", {30'd0, core_rst_n}, 32'd0);
        chk("rst_coreen", {30'd0, core_en}, 32'd0);
        chk("rst_kv", {31'd0, key_valid}, 32'd0);
        chk("rst_key", 32'(key), 32'd0);
        chk("rst_win", {31'd0, winner}, 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        chk("rel_rdy", {31'd0, rdy}, 32'd1);
        chk("rel_crst", {30'd0, core_rst_n}, 32'd3);
        wait_rdy();

        run_search(300, 1'b0, 24'h000000, 100, 1'b1, 24'h00002B);
        wait_rdy();
        run_search(40, 1'b1, 24'h000010, 40, 1'b1, 24'h000011);
        wait_rdy();
        run_search(50, 1'b0, 24'h000000, 80, 1'b0, 24'h000000);
        wait_rdy();
        run_search(30, 1'b0, 24'h000000, 60, 1'b1, 24'h123457);
        wait_rdy();
        run_search(25, 1'b1, 24'hABCDE0, 200, 1'b0, 24'h000000);
        wait_rdy();

        // Reset in the middle of a search; a second en during RUN is ignored.
        c_dur[0] = 500; c_val[0] = 1'b0;
        c_dur[1] = 500; c_val[1] = 1'b0;
        en = 1'b1;
        @(negedge clk);
        en = 1'b0;
        repeat (20) @(negedge clk);
        en = 1'b1;
        for (int i = 0; i < 4; i++) begin
            @(negedge clk);
            chk("run_en_rdy", {31'd0, rdy}, 32'd0);
            chk("run_en_coreen", {30'd0, core_en}, 32'd0);
        end
        en    = 1'b0;
        rst_n = 1'b0;
        @(negedge clk);
        chk("mid_rst_rdy", {31'd0, rdy}, 32'd0);
        chk("mid_rst_crst", {30'd0, core_rst_n}, 32'd0);
        chk("mid_rst_kv", {31'd0, key_valid}, 32'd0);
        chk("mid_rst_key", 32'(key), 32'd0);
        chk("mid_rst_win", {31'd0, winner}, 32'd0);
        chk("mid_rst_coreen", {30'd0, core_en}, 32'd0);
`ifdef CRACK_CYCLE_COUNT_EN
        chk("mid_rst_cyc", search_cycles, 32'd0);
`endif
        rst_n = 1'b1;
        @(negedge clk);
        chk("mid_rel_rdy", {31'd0, rdy}, 32'd1);
        chk("mid_rel_crst", {30'd0, core_rst_n}, 32'd3);
        wait_rdy();

        run_search(10, 1'b1, 24'h000002, 10, 1'b0, 24'h000000);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
